uart_tx_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares the single 8-bit UART transmitter of tt_um_uart_8bit among NUM_REQ byte-stream requesters.
- Accepts bytes over per-requester valid/ready handshakes and latches the winning byte.
- Drives the UART's level-sensitive tx_start / tx_data inputs and tracks tx_ready through accept and completion.
- Sits between on-chip byte sources (command responder, status reporter, debug tap) and the UART TX datapath.

---
 rtl/uart_arb_pkg.sv | 14 +
 rtl/uart_tx_arbiter_rr_picker.sv | 35 +++
 rtl/uart_tx_arbiter.sv | 154 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2
  } arb_state_e;

  localparam logic [15:0] START_TIMEOUT_DEF = 16'd1024;

  typedef logic [7:0] uart_byte_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// rr_picker: combinational round-robin select. It scans upward from ptr+1 with
// wrap-around and returns the first valid requester as one-hot and index.
module rr_picker #(
  parameter int N = 4
) (
  input  logic [N-1:0]         valid,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx,
  output logic                 found
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] cand_s;

  // First valid requester after the pointer wins.
  always_comb begin
    grant  = {N{1'b0}};
    idx    = {IW{1'b0}};
    found  = 1'b0;
    cand_s = {IW{1'b0}};
    for (int k = 1; k <= N; k++) begin
      cand_s = IW'((int'(ptr) + k) % N);
      if (!found && valid[cand_s]) begin
        found         = 1'b1;
        grant[cand_s] = 1'b1;
        idx           = cand_s;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among NUM_REQ
// byte sources. Optional burst locking is enabled with UART_ARB_BURST_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int          NUM_REQ       = 4,
  parameter logic [15:0] START_TIMEOUT = START_TIMEOUT_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*8-1:0]       req_data,
`ifdef UART_ARB_BURST_EN
  input  logic [NUM_REQ-1:0]         req_last,
`endif
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [7:0]                 tx_data,
  output logic                       tx_start,
  input  logic                       tx_ready,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       timeout_err
);

  localparam int IDW = $clog2(NUM_REQ);

  arb_state_e       state_r, state_nxt_s;
  logic [15:0]      cnt_r;
  logic             tx_start_r, busy_r, timeout_err_r;
  uart_byte_t       tx_data_r;
  logic [IDW-1:0]   grant_id_r, ptr_r;
  uart_byte_t       req_bytes_s [NUM_REQ];
  logic [NUM_REQ-1:0] pick_valid_s, pick_grant_s;
  logic [IDW-1:0]   pick_idx_s;
  logic             pick_found_s, accept_s, timeout_s;
`ifdef UART_ARB_BURST_EN
  logic             lock_r;
`endif

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
    assign req_bytes_s[g] = req_data[8*g +: 8];
  end

  // While a burst holds the grant only its owner may be picked.
  always_comb begin
    pick_valid_s = req_valid;
`ifdef UART_ARB_BURST_EN
    if (lock_r) begin
      pick_valid_s             = {NUM_REQ{1'b0}};
      pick_valid_s[grant_id_r] = req_valid[grant_id_r];
    end else begin
      pick_valid_s = req_valid;
    end
`endif
  end

  rr_picker #(.N(NUM_REQ)) u_picker (
    .valid (pick_valid_s),
    .ptr   (ptr_r),
    .grant (pick_grant_s),
    .idx   (pick_idx_s),
    .found (pick_found_s)
  );

  // Next-state logic and the combinational accept strobe.
  always_comb begin
    state_nxt_s = state_r;
    req_ready   = {NUM_REQ{1'b0}};
    accept_s    = 1'b0;
    timeout_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (tx_ready && pick_found_s) begin
          accept_s    = 1'b1;
          req_ready   = pick_grant_s;
          state_nxt_s = START;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      START: begin
        if (!tx_ready) begin
          state_nxt_s = WAIT_DONE;
        end else if (cnt_r == START_TIMEOUT - 16'd1) begin
          timeout_s   = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = START;
        end
      end
      WAIT_DONE: begin
        if (tx_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT_DONE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, timeout counter and registered UART-facing outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      cnt_r         <= 16'd0;
      tx_start_r    <= 1'b0;
      tx_data_r     <= 8'h00;
      grant_id_r    <= {IDW{1'b0}};
      ptr_r         <= IDW'(NUM_REQ - 1);
      busy_r        <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      tx_start_r    <= (state_nxt_s == START);
      busy_r        <= (state_nxt_s != IDLE);
      timeout_err_r <= timeout_s;
      if (state_r == START && state_nxt_s == START) begin
        cnt_r <= cnt_r + 16'd1;
      end else begin
        cnt_r <= 16'd0;
      end
      if (accept_s) begin
        tx_data_r  <= req_bytes_s[pick_idx_s];
        grant_id_r <= pick_idx_s;
        ptr_r      <= pick_idx_s;
      end else begin
        tx_data_r  <= tx_data_r;
      end
    end
  end

`ifdef UART_ARB_BURST_EN
  // Burst ownership: held until a byte flagged last, dropped on timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_r <= 1'b0;
    end else if (accept_s) begin
      lock_r <= !req_last[pick_idx_s];
    end else if (timeout_s) begin
      lock_r <= 1'b0;
    end else begin
      lock_r <= lock_r;
    end
  end
`endif

  assign tx_start    = tx_start_r;
  assign tx_data     = tx_data_r;
  assign grant_id    = grant_id_r;
  assign busy        = busy_r;
  assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (NUM_REQ=4, START_TIMEOUT=16).
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_ready;
  logic [1:0]  grant_id;
  logic        busy;
  logic        timeout_err;

  int err_cnt = 0;
  int chk_cnt = 0;
  int hi_cnt;
  int rr_cnt;
  int to_cnt;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(4), .START_TIMEOUT(16'd16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
`ifdef UART_ARB_BURST_EN
    .req_last    (req_last),
`endif
    .req_ready   (req_ready),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_ready    (tx_ready),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  // Entered just after a negedge in IDLE with inputs set; one full byte with a quick UART.
  task automatic do_byte(input int id, input logic [7:0] d);
    check_eq("rr_ready", {28'd0, req_ready}, 32'd1 << id);
    @(negedge clk); #1;
    check_eq("rr_start", {31'd0, tx_start}, 32'd1);
    check_eq("rr_data", {24'd0, tx_data}, {24'd0, d});
    check_eq("rr_gid", {30'd0, grant_id}, id);
    tx_ready = 1'b0;
    @(negedge clk); #1;
    tx_ready = 1'b1;
    @(negedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'b0000;
    req_data  = {8'h13, 8'hA5, 8'h11, 8'h10};
    req_last  = 4'b1111;
    tx_ready  = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_start", {31'd0, tx_start}, 32'd0);
    check_eq("rst_data", {24'd0, tx_data}, 32'd0);
    check_eq("rst_gid", {30'd0, grant_id}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_to", {31'd0, timeout_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Single request from requester 2, UART busy for 250 cycles.
    req_valid = 4'b0100;
    #1;
    check_eq("t1_ready", {28'd0, req_ready}, 32'h4);
    @(negedge clk); #1;
    req_valid = 4'b0000;
    check_eq("t1_start1", {31'd0, tx_start}, 32'd1);
    check_eq("t1_data", {24'd0, tx_data}, 32'hA5);
    check_eq("t1_gid", {30'd0, grant_id}, 32'd2);
    check_eq("t1_busy", {31'd0, busy}, 32'd1);
    @(negedge clk); #1;
    check_eq("t1_start2", {31'd0, tx_start}, 32'd1);
    tx_ready = 1'b0;
    @(negedge clk); #1;
    check_eq("t1_start_lo", {31'd0, tx_start}, 32'd0);
    check_eq("t1_busy_wait", {31'd0, busy}, 32'd1);
    hi_cnt = 0;
    rr_cnt = 0;
    repeat (250) begin
      @(negedge clk); #1;
      if (tx_start) hi_cnt++;
      if (req_ready != 4'b0000) rr_cnt++;
    end
    check_eq("t1_no_start", hi_cnt, 32'd0);
    check_eq("t1_no_ready", rr_cnt, 32'd0);
    tx_ready = 1'b1;
    @(negedge clk); #1;
    check_eq("t1_busy_end", {31'd0, busy}, 32'd0);
    check_eq("t1_data_hold", {24'd0, tx_data}, 32'hA5);

    // Four continuous requesters after reset: 0,1,2,3,0.
    do_reset();
    req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    req_valid = 4'b1111;
    #1;
    do_byte(0, 8'h10);
    do_byte(1, 8'h11);
    do_byte(2, 8'h12);
    do_byte(3, 8'h13);
    do_byte(0, 8'h10);

    // Start timeout: UART never leaves ready.
    req_valid = 4'b0010;
    #1;
    check_eq("t3_ready", {28'd0, req_ready}, 32'h2);
    hi_cnt = 0;
    to_cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk); #1;
      if (i == 1) req_valid = 4'b0000;
      if (tx_start) hi_cnt++;
      if (timeout_err) to_cnt++;
      if (i == 17) begin
        check_eq("t3_to_pulse", {31'd0, timeout_err}, 32'd1);
        check_eq("t3_idle", {31'd0, busy}, 32'd0);
      end
    end
    check_eq("t3_hi_cycles", hi_cnt, 32'd16);
    check_eq("t3_to_count", to_cnt, 32'd1);
    req_valid = 4'b1000;
    #1;
    do_byte(3, 8'h13);

    // UART not ready at request time.
    tx_ready  = 1'b0;
    req_valid = 4'b0001;
    #1;
    rr_cnt = 0;
    repeat (3) begin
      @(negedge clk); #1;
      if (req_ready != 4'b0000 || busy) rr_cnt++;
    end
    check_eq("t4_held", rr_cnt, 32'd0);
    tx_ready = 1'b1;
    #1;
    do_byte(0, 8'h10);

    // Reset during WAIT_DONE.
    req_valid = 4'b0100;
    #1;
    check_eq("t5_ready", {28'd0, req_ready}, 32'h4);
    @(negedge clk); #1;
    check_eq("t5_start", {31'd0, tx_start}, 32'd1);
    req_valid = 4'b0000;
    tx_ready  = 1'b0;
    @(negedge clk); #1;
    check_eq("t5_wait_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("t5_rst_data", {24'd0, tx_data}, 32'd0);
    check_eq("t5_rst_gid", {30'd0, grant_id}, 32'd0);
    check_eq("t5_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("t5_rst_start", {31'd0, tx_start}, 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    tx_ready  = 1'b1;
    req_valid = 4'b1111;
    #1;
    do_byte(0, 8'h10);

`ifdef UART_ARB_BURST_EN
    // Burst from requester 1 while requester 0 stays valid.
    req_valid = 4'b0011;
    req_last  = 4'b0001;
    req_data  = {8'h13, 8'h12, 8'h21, 8'h10};
    #1;
    do_byte(1, 8'h21);
    req_data[15:8] = 8'h22;
    #1;
    do_byte(1, 8'h22);
    req_data[15:8] = 8'h23;
    req_last = 4'b0011;
    #1;
    do_byte(1, 8'h23);
    do_byte(0, 8'h10);
`endif

    req_valid = 4'b0000;
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
